vscale_htif_pcr_responder: RTL and testbench

//   Core-side responder for the HTIF PCR request/response channel. Services host read/write

---
 rtl/vscale_htif_pcr_responder.sv | 141 ++++++++++++++
 tb/tb_vscale_htif_pcr_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vscale_htif_pcr_responder.sv
// vscale_htif_pcr_responder
//   Core-side responder for the HTIF PCR request/response channel. It services
//   host reads and writes to the tohost/fromhost mailbox CSRs and returns one
//   response per accepted request. The response data is the register value
//   before the access. A host read of tohost also clears tohost.
//
// Ports
//   clk                    clock
//   reset                  synchronous, active-low reset
//   i_htif_pcr_req_valid   host request valid
//   o_htif_pcr_req_ready   responder can accept a request (IDLE)
//   i_htif_pcr_req_rw      1 = write, 0 = read
//   i_htif_pcr_req_addr    CSR address
//   i_htif_pcr_req_data    write data
//   o_htif_pcr_resp_valid  response valid (RESP)
//   i_htif_pcr_resp_ready  host accepts response
//   o_htif_pcr_resp_data   response data (old register value)
//   i_core_tohost_wen      core writes tohost this cycle
//   i_core_tohost_wdata    core tohost write data
//   o_core_tohost_busy     tohost != 0
//   i_core_fromhost_clr    core clears fromhost this cycle
//   o_fromhost             current fromhost value
//   o_fromhost_valid       fromhost != 0
module vscale_htif_pcr_responder #(
  parameter int PCR_WIDTH  = 64,
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] ADDR_TOHOST   = 12'h780,
  parameter logic [ADDR_WIDTH-1:0] ADDR_FROMHOST = 12'h781
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_htif_pcr_req_valid,
  output logic                  o_htif_pcr_req_ready,
  input  logic                  i_htif_pcr_req_rw,
  input  logic [ADDR_WIDTH-1:0] i_htif_pcr_req_addr,
  input  logic [PCR_WIDTH-1:0]  i_htif_pcr_req_data,
  output logic                  o_htif_pcr_resp_valid,
  input  logic                  i_htif_pcr_resp_ready,
  output logic [PCR_WIDTH-1:0]  o_htif_pcr_resp_data,
  input  logic                  i_core_tohost_wen,
  input  logic [PCR_WIDTH-1:0]  i_core_tohost_wdata,
  output logic                  o_core_tohost_busy,
  input  logic                  i_core_fromhost_clr,
  output logic [PCR_WIDTH-1:0]  o_fromhost,
  output logic                  o_fromhost_valid
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [PCR_WIDTH-1:0] r_tohost;
  logic [PCR_WIDTH-1:0] r_fromhost;
  logic [PCR_WIDTH-1:0] r_resp_data;

  logic                 w_accept;
  logic                 w_hit_tohost;
  logic                 w_hit_fromhost;
  logic [PCR_WIDTH-1:0] w_read_value;

  assign w_hit_tohost   = (i_htif_pcr_req_addr == ADDR_TOHOST);
  assign w_hit_fromhost = (i_htif_pcr_req_addr == ADDR_FROMHOST);

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next          = r_state;
    w_accept              = 1'b0;
    o_htif_pcr_req_ready  = 1'b0;
    o_htif_pcr_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_htif_pcr_req_ready = 1'b1;
        if (i_htif_pcr_req_valid) begin
          w_accept     = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        o_htif_pcr_resp_valid = 1'b1;
        if (i_htif_pcr_resp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pre-access value of the addressed register; unmapped addresses read 0.
  always_comb begin
    w_read_value = '0;
    if (w_hit_tohost) begin
      w_read_value = r_tohost;
    end else if (w_hit_fromhost) begin
      w_read_value = r_fromhost;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_resp_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_resp_data <= w_read_value;
      end
    end
  end

  // Core write has priority over any host access to tohost; a host read
  // otherwise consumes (clears) the mailbox.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tohost <= '0;
    end else if (i_core_tohost_wen) begin
      r_tohost <= i_core_tohost_wdata;
    end else if (w_accept && w_hit_tohost) begin
      r_tohost <= i_htif_pcr_req_rw ? i_htif_pcr_req_data : '0;
    end
  end

  // A host write to fromhost wins over a simultaneous core clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fromhost <= '0;
    end else if (w_accept && w_hit_fromhost && i_htif_pcr_req_rw) begin
      r_fromhost <= i_htif_pcr_req_data;
    end else if (i_core_fromhost_clr) begin
      r_fromhost <= '0;
    end
  end

  assign o_htif_pcr_resp_data = r_resp_data;
  assign o_core_tohost_busy   = (r_tohost != '0);
  assign o_fromhost           = r_fromhost;
  assign o_fromhost_valid     = (r_fromhost != '0);

endmodule

// File: tb/tb_vscale_htif_pcr_responder.sv
// tb_vscale_htif_pcr_responder
//   Directed and randomized bench for vscale_htif_pcr_responder. A
//   transaction-level model of the two mailboxes and the pending response
//   predicts every output after each clock edge.
module tb_vscale_htif_pcr_responder;

  localparam logic [11:0] TOHOST   = 12'h780;
  localparam logic [11:0] FROMHOST = 12'h781;

  logic        clk;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqRw;
  logic [11:0] reqAddr;
  logic [63:0] reqData;
  logic        respValid;
  logic        respReady;
  logic [63:0] respData;
  logic        coreWen;
  logic [63:0] coreWdata;
  logic        coreBusy;
  logic        coreClr;
  logic [63:0] fromhost;
  logic        fromhostValid;

  int checks = 0;
  int errors = 0;

  // Reference model state: mailbox contents and the outstanding response.
  logic [63:0] mTohost   = '0;
  logic [63:0] mFromhost = '0;
  bit          mPending  = 1'b0;
  logic [63:0] mResp     = '0;

  vscale_htif_pcr_responder dut (
    .clk                   (clk),
    .reset                 (reset),
    .i_htif_pcr_req_valid  (reqValid),
    .o_htif_pcr_req_ready  (reqReady),
    .i_htif_pcr_req_rw     (reqRw),
    .i_htif_pcr_req_addr   (reqAddr),
    .i_htif_pcr_req_data   (reqData),
    .o_htif_pcr_resp_valid (respValid),
    .i_htif_pcr_resp_ready (respReady),
    .o_htif_pcr_resp_data  (respData),
    .i_core_tohost_wen     (coreWen),
    .i_core_tohost_wdata   (coreWdata),
    .o_core_tohost_busy    (coreBusy),
    .i_core_fromhost_clr   (coreClr),
    .o_fromhost            (fromhost),
    .o_fromhost_valid      (fromhostValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("req_ready", {63'b0, reqReady}, {63'b0, !mPending});
    checkOutput("resp_valid", {63'b0, respValid}, {63'b0, mPending});
    if (mPending) checkOutput("resp_data", respData, mResp);
    checkOutput("tohost_busy", {63'b0, coreBusy}, {63'b0, mTohost != 64'd0});
    checkOutput("fromhost", fromhost, mFromhost);
    checkOutput("fromhost_valid", {63'b0, fromhostValid}, {63'b0, mFromhost != 64'd0});
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic applyStimulus(input logic rst, input logic v, input logic rw,
                               input logic [11:0] a, input logic [63:0] d,
                               input logic rr, input logic cw,
                               input logic [63:0] cwd, input logic fc);
    bit          accepted;
    logic [63:0] oldT;
    logic [63:0] oldF;
    reset     = rst;
    reqValid  = v;
    reqRw     = rw;
    reqAddr   = a;
    reqData   = d;
    respReady = rr;
    coreWen   = cw;
    coreWdata = cwd;
    coreClr   = fc;
    @(posedge clk);
    if (!rst) begin
      mTohost   = '0;
      mFromhost = '0;
      mPending  = 1'b0;
      mResp     = '0;
    end else begin
      accepted = !mPending && v;
      oldT     = mTohost;
      oldF     = mFromhost;
      if (mPending && rr) mPending = 1'b0;
      if (accepted) begin
        mPending = 1'b1;
        mResp    = (a == TOHOST) ? oldT : (a == FROMHOST) ? oldF : 64'd0;
      end
      if (cw) mTohost = cwd;
      else if (accepted && a == TOHOST) mTohost = rw ? d : 64'd0;
      if (accepted && a == FROMHOST && rw) mFromhost = d;
      else if (fc) mFromhost = 64'd0;
    end
    #1;
    checkAll();
  endtask

  task automatic idleCycle(input logic rr);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 64'd0, rr, 1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    logic [11:0] addr;
    logic        rr;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    checkOutput("reset_resp_data", respData, 64'd0);
    checkOutput("reset_req_ready", {63'b0, reqReady}, 64'd1);

    // Core posts tohost=1, host reads it back, second read returns 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 64'd0, 1'b0, 1'b1, 64'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, TOHOST, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    checkOutput("read_tohost_data", respData, 64'd1);
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, TOHOST, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
    checkOutput("reread_tohost_data", respData, 64'd0);
    idleCycle(1'b1);

    // Host read of tohost colliding with a core write.
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 64'd0, 1'b0, 1'b1, 64'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, TOHOST, 64'd0, 1'b1, 1'b1, 64'd5, 1'b0);
    checkOutput("collide_resp", respData, 64'd3);
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, TOHOST, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
    checkOutput("collide_after", respData, 64'd5);
    idleCycle(1'b1);

    // Host writes fromhost and stalls the response for four cycles.
    applyStimulus(1'b1, 1'b1, 1'b1, FROMHOST, 64'hA5, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) idleCycle(1'b0);
    checkOutput("stall_fromhost", fromhost, 64'hA5);
    idleCycle(1'b1);

    // Host write to fromhost beats a simultaneous core clear.
    applyStimulus(1'b1, 1'b1, 1'b1, FROMHOST, 64'h7, 1'b1, 1'b0, 64'd0, 1'b1);
    idleCycle(1'b1);
    checkOutput("write_beats_clr", fromhost, 64'h7);
    // Unmapped address reads as zero.
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h123, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
    checkOutput("unmapped_resp", respData, 64'd0);
    idleCycle(1'b1);

    // Reset while a response is outstanding.
    applyStimulus(1'b1, 1'b1, 1'b0, FROMHOST, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    checkOutput("reset_in_resp", {63'b0, respValid}, 64'd0);
    idleCycle(1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    addr = ($urandom_range(0, 1) != 0) ? TOHOST : FROMHOST;
        default: addr = 12'($urandom_range(0, 4095));
      endcase
      rr = ($urandom_range(0, 3) != 0);
      applyStimulus(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), addr,
                    {32'($urandom_range(0, 3)), $urandom}, rr,
                    ($urandom_range(0, 5) == 0), {$urandom, $urandom},
                    ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
